vfilter_mul_scheduler: RTL
==========================

Name: vfilter_mul_scheduler

Overview:
- Time-multiplexes one shared constant-multiply carry-chain unit in the vertical edge filter among N_REQ row/tap requesters.
- Arbitrates requests round-robin and issues one operand per cycle to the unit.
- Tracks each operation's tag through the unit's fixed pipeline latency.
- Returns results through a credit-protected response FIFO with valid/ready backpressure.

Parameters:
- N_REQ, 4, number of requesters (power of two, >=2)
- DW, 24, operand width (pdata_2_3y width)
- RW, 25, result width returned by the shared unit
- MUL_LAT, 2, cycles from mul_valid high to mul_res valid (>=1)
- FIFO_DEPTH, 4, response FIFO entries; also the max outstanding ops (>=MUL_LAT+1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  N_REQ  per-requester operand valid
- req_data  in  N_REQ*DW  packed operands; requester i occupies [i*DW +: DW]
- req_ready  out  N_REQ  one-hot grant, combinational
- mul_a  out  DW  operand to shared unit, registered
- mul_valid  out  1  operand issue strobe, registered
- mul_res  in  RW  unit result, sampled MUL_LAT cycles after mul_valid
- rsp_valid  out  1  response FIFO non-empty
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  RW  result at FIFO head
- rsp_tag  out  log2(N_REQ)  requester index of head result
- busy  out  1  outstanding != 0

Behaviour:
- Reset (async, any time): mul_valid=0, mul_a=0, rsp_valid=0, busy=0, round-robin pointer=0, outstanding=0, FIFO and tag pipe cleared. Operations in flight are discarded; the unit's later mul_res is ignored because the tag-pipe valid bits are cleared.
- Credit: outstanding = ops accepted but not yet popped; range 0..FIFO_DEPTH. The arbiter grants only if outstanding < FIFO_DEPTH. A pop in the same cycle does not add a credit (no lookahead).
- Arbitration: among requesters with req_valid=1, grant the first at or after the pointer, wrapping modulo N_REQ. req_ready has at most one bit set and is never set for an invalid requester, so every grant is a transfer.
- Pointer update: on transfer, pointer <= granted+1 mod N_REQ. With no transfer the pointer holds.
- Issue: on transfer at edge T, mul_a <= the selected operand and mul_valid <= 1 at T. mul_valid=0 on any cycle with no transfer; mul_a then holds its value.
- Tag pipe: MUL_LAT-stage shift register of {valid, tag}. When the output stage is valid, {mul_res, tag} is written to the FIFO on that edge.
- Latency: requester handshake at edge T -> rsp_valid high after edge T+MUL_LAT+1, provided the FIFO is empty and the consumer is ready.
- Order: responses are strictly in accept order, with no reordering.
- Outstanding update: +1 on transfer, -1 on rsp_valid&rsp_ready, unchanged when both occur.
- FIFO: cannot overflow by construction; a write into a full FIFO is an assertion failure. A pop with an empty FIFO is impossible because rsp_valid=0. Write and pop in the same cycle are both honoured.
- Throughput: one op per cycle sustained while rsp_ready=1 and FIFO_DEPTH >= MUL_LAT+2. With FIFO_DEPTH = MUL_LAT+1, issue stalls one cycle in every FIFO_DEPTH+1 cycles (documented, not a bug).

Test Plan:
- Single request. Params default; bench unit model returns a*3 with 2-cycle latency. req_valid=0001, data=5 at edge 0 -> mul_valid at edge 0, rsp_valid after edge 3, rsp_data=15, rsp_tag=0, busy falls after pop.
- Full contention. req_valid=1111 held, rsp_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles; rsp_tag sequence 0,1,2,3,0,1; no gaps after fill.
- Backpressure. rsp_ready=0, all requesting -> exactly 4 transfers, then req_ready=0000 and busy=1. Raise rsp_ready -> one grant per pop; no FIFO overflow assertion fires.
- Simultaneous accept and pop. With outstanding=3, a transfer and a pop occur in the same cycle -> outstanding stays 3 and the next cycle still grants.
- Wrap and skip. Pointer=3 and only req_valid[1]=1 -> grant 1, pointer becomes 2.
- Reset mid-operation. Assert rst with 3 ops in flight -> same cycle rsp_valid=0, mul_valid=0, busy=0. After release, stale mul_res is not captured and the first grant with 1111 goes to requester 0.

Source files
------------

// File: rtl/vfilter_mul_scheduler_if.sv
// Handshake bundle for the vertical-filter multiply scheduler.
// slave: scheduler side. master: requesters, shared unit and consumer.
//   req_valid/req_data/req_ready : per-requester operand handshake
//   mul_a/mul_valid/mul_res      : shared multiply unit
//   rsp_valid/rsp_ready/rsp_data/rsp_tag : response stream
//   busy                         : ops outstanding
interface vfilter_mul_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int DW    = 24,
  parameter int RW    = 25,
  parameter int TW    = $clog2(N_REQ)
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic [DW-1:0]       mul_a;
  logic                mul_valid;
  logic [RW-1:0]       mul_res;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [RW-1:0]       rsp_data;
  logic [TW-1:0]       rsp_tag;
  logic                busy;

  modport slave (
    input  req_valid,
    input  req_data,
    input  mul_res,
    input  rsp_ready,
    output req_ready,
    output mul_a,
    output mul_valid,
    output rsp_valid,
    output rsp_data,
    output rsp_tag,
    output busy
  );

  modport master (
    output req_valid,
    output req_data,
    output mul_res,
    output rsp_ready,
    input  req_ready,
    input  mul_a,
    input  mul_valid,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_tag,
    input  busy
  );
endinterface

// File: rtl/vfilter_mul_scheduler.sv
// Shares one constant-multiply unit among N_REQ requesters.
// Ports: clk, rst (async, active-high), bus (slave modport):
//   round-robin grant on req_*, registered issue on mul_a/
//   mul_valid, result capture from mul_res MUL_LAT cycles
//   later into a credit-protected FIFO drained on rsp_*.
module vfilter_mul_scheduler #(
  parameter int N_REQ      = 4,
  parameter int DW         = 24,
  parameter int RW         = 25,
  parameter int MUL_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst,
  vfilter_mul_scheduler_if.slave bus
);
  localparam int TW = $clog2(N_REQ);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = (FIFO_DEPTH > 1) ?
                      $clog2(FIFO_DEPTH) : 1;

  logic [TW-1:0] ptr;
  logic [TW-1:0] gnt_idx;
  logic          gnt_any;
  logic          credit_ok;
  logic          xfer;
  logic [DW-1:0] sel;

  logic [CW-1:0] outstanding;

  logic          iss_valid;
  logic [DW-1:0] iss_a;
  logic [TW-1:0] iss_tag;

  logic [MUL_LAT-1:0] tp_v;
  logic [TW-1:0]      tp_tag [MUL_LAT];
  logic               wr;
  logic [TW-1:0]      wr_tag;

  logic [RW-1:0] f_data [FIFO_DEPTH];
  logic [TW-1:0] f_tag  [FIFO_DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          f_nempty;
  logic          rd;

  // Search starts at ptr; TW-bit add wraps mod N_REQ.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_any &&
          bus.req_valid[ptr + TW'(k)]) begin
        gnt_any = 1'b1;
        gnt_idx = ptr + TW'(k);
      end
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == TW'(i)) begin
        sel = bus.req_data[i*DW +: DW];
      end
    end
  end

  // No lookahead on a same-cycle pop.
  assign credit_ok = outstanding < CW'(FIFO_DEPTH);
  assign xfer      = gnt_any && credit_ok;

  always_comb begin
    bus.req_ready = '0;
    if (xfer) begin
      bus.req_ready[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      iss_valid <= 1'b0;
      iss_a     <= '0;
      iss_tag   <= '0;
    end else begin
      iss_valid <= xfer;
      if (xfer) begin
        ptr     <= gnt_idx + TW'(1);
        iss_a   <= sel;
        iss_tag <= gnt_idx;
      end
    end
  end

  assign bus.mul_valid = iss_valid;
  assign bus.mul_a     = iss_a;

  // Stage 0 follows the issue register, so the last stage
  // lines up with mul_res MUL_LAT cycles after mul_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tp_v <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        tp_tag[i] <= '0;
      end
    end else begin
      tp_v[0]   <= iss_valid;
      tp_tag[0] <= iss_tag;
      for (int i = 1; i < MUL_LAT; i++) begin
        tp_v[i]   <= tp_v[i-1];
        tp_tag[i] <= tp_tag[i-1];
      end
    end
  end

  assign wr     = tp_v[MUL_LAT-1];
  assign wr_tag = tp_tag[MUL_LAT-1];

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(FIFO_DEPTH - 1)) ?
           '0 : p + AW'(1);
  endfunction

  assign f_nempty = cnt != '0;
  assign rd       = f_nempty && bus.rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) begin
        wp <= nxt(wp);
      end
      if (rd) begin
        rp <= nxt(rp);
      end
      unique case ({wr, rd})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: cnt gates every read.
  always_ff @(posedge clk) begin
    if (wr) begin
      f_data[wp] <= bus.mul_res;
      f_tag[wp]  <= wr_tag;
    end
  end

  assign bus.rsp_valid = f_nempty;
  assign bus.rsp_data  = f_data[rp];
  assign bus.rsp_tag   = f_tag[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      unique case ({xfer, rd})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign bus.busy = outstanding != '0;

  // Credits bound in-flight ops to the free FIFO slots.
  a_no_overflow : assert property (
    @(posedge clk) disable iff (rst)
    !(wr && cnt == CW'(FIFO_DEPTH))
  );

endmodule
